alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle control sequencer that drives the datapath ALU (module `alu`) from a small program memory. It performs the following steps for each instruction:
- fetches an 8-bit instruction;
- reads one operand from a data memory;
- presents opcode, accumulator, operand and carry-in to the ALU;
- writes the ALU result back into an accumulator, and writes carry/overflow into flag registers.

It sits above the ALU as its sole initiator. The ALU is instantiated beside it at top level, not inside it.

## Interface
- WIDTH, 8, datapath width; must match the ALU.
- AW, 4, address width of both program and data memory (16 entries each).
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution at pc 0; honoured only in IDLE or HALTED
- imem_addr  out  AW  program memory address, always equals pc
- imem_rdata  in  8  instruction; synchronous read, valid one cycle after address
- dmem_addr  out  AW  data memory read address
- dmem_rdata  in  WIDTH  operand; synchronous read, valid one cycle after address
- alu_op  out  3  ALU opcode; 3'b000 outside EXEC
- alu_a  out  WIDTH  always acc
- alu_b  out  WIDTH  always dmem_rdata
- alu_ci  out  1  ir[4] & flag_c during EXEC, else 0
- alu_result  in  WIDTH  ALU result
- alu_co, alu_ov  in  1 each  ALU carry / overflow
- acc  out  WIDTH  accumulator
- flag_c, flag_v  out  1 each  carry / overflow flags
- busy  out  1  high in FETCH, DECODE, EXEC
- halted  out  1  high in HALTED
- instr_done  out  1  one-cycle pulse on the last EXEC cycle of each executed instruction
- step  in  1  present only with ALU_SEQ_STEP_EN

## Operation
- Instruction word fields:
  - [7:5] opcode: 000 NOP, 001 LD, 010 ADD, 011 SUB, 100 NOT, 101 AND, 110 OR, 111 XOR.
  - [4] use-carry.
  - [3:0] operand address; for widths other than AW, [AW-1:0] is used.
- HALT is the exact encoding 8'h0F. Any other NOP encoding is a plain NOP.
- State machine states: IDLE, FETCH, DECODE, EXEC, HALTED (plus STEP_WAIT when ALU_SEQ_STEP_EN is defined).
- IDLE: start → FETCH. On that transition pc, acc, flag_c and flag_v are all cleared to 0.
- FETCH: imem_addr=pc; → DECODE.
- DECODE: latch ir ← imem_rdata. dmem_addr = imem_rdata[AW-1:0] combinationally in this state; in all other states dmem_addr = ir[AW-1:0]. If imem_rdata == 8'h0F → HALTED, otherwise → EXEC.
- EXEC, ALU drive:
  - alu_op = ir[7:5].
  - alu_ci = ir[4] & flag_c, for ADD/SUB only; 0 for all other ops.
- EXEC, end-of-cycle writes:
  - acc ← alu_result, unless the op is NOP.
  - flag_c ← alu_co and flag_v ← alu_ov for ADD/SUB only; every other op preserves both flags.
  - pc ← pc+1, wrapping from 2^AW−1 to 0.
  - instr_done=1.
  - → FETCH.
- HALTED: pc stays at the HALT address; acc and flags are held. start → FETCH with the same clearing as from IDLE.
- start is ignored while busy.
- rst in any state at the next edge: state IDLE, pc 0, acc 0, flag_c 0, flag_v 0. Any in-flight EXEC write is discarded.

## Timing
- Reset values of outputs:
  - imem_addr 0, dmem_addr 0, alu_op 0, alu_ci 0, acc 0, flags 0.
  - busy 0, halted 0, instr_done 0.
  - alu_a = 0, because it tracks acc.
- Each instruction takes exactly 3 cycles (FETCH, DECODE, EXEC), including NOP.
- HALT takes 2 cycles (FETCH, DECODE); halted is asserted the cycle after DECODE.
- start high in cycle n → FETCH in cycle n+1 → first instr_done in cycle n+3.
- ALU path is combinational within EXEC; no registers between alu_* outputs and the result capture.

## Configuration
- ALU_SEQ_STEP_EN defined:
  - Adds the `step` port and the STEP_WAIT state.
  - EXEC → STEP_WAIT instead of FETCH. busy stays high in STEP_WAIT.
  - STEP_WAIT → FETCH on the cycle step=1.
  - rst from STEP_WAIT → IDLE.
- ALU_SEQ_STEP_EN undefined: no step port and no STEP_WAIT; continuous execution.

## Structure
- Shared package `alu_seq_pkg` contains:
  - opcode localparams OP_NOP..OP_XOR;
  - HALT_INSTR = 8'h0F;
  - state enum `alu_seq_state_e`;
  - field-position constants for the instruction word.
- One natural sub-module: `alu_seq_decode`, combinational. It maps the instruction byte to:
  - op;
  - use_carry;
  - operand address;
  - is_halt;
  - writes_acc;
  - writes_flags.

## Test plan
- Load and add with overflow, WIDTH=8:
  - imem = {0x21, 0x41, 0x0F}, dmem[1] = 0x7F; pulse start.
  - Required: acc=0xFE, flag_v=1, flag_c=0; instr_done pulses in cycles 3 and 6 after start; halted in cycle 9.
- Carry chain:
  - imem = {0x22, 0x41, 0x53, 0x0F}, dmem = {x, 0x01, 0xFF, 0x00}.
  - Required: after the ADD, acc=0x00 and flag_c=1; after the ADD-with-carry, acc=0x01 and flag_c=0.
- Flag preservation:
  - Set flag_c=1 with an ADD, then run XOR (0xE1).
  - Required: flag_c still 1 and acc updated.
- Reset mid-EXEC:
  - Assert rst during EXEC of an ADD.
  - Required: next cycle acc=0, flags 0, state IDLE, busy 0, no instr_done.
- PC wrap:
  - All 16 imem words = 0x00; pulse start.
  - Required: pc returns to 0 after 48 cycles; start pulses while busy are ignored; acc is unchanged.
- With ALU_SEQ_STEP_EN, program {0x21, 0x0F}:
  - Required: sequencer holds in STEP_WAIT with busy=1 until step; halted is asserted 3 cycles after the step pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, instruction-word field positions and sequencer
// state type for the alu_seq control sequencer.
// The STEP_WAIT state exists only when ALU_SEQ_STEP_EN is defined.
package alu_seq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [7:0] HALT_INSTR = 8'h0F;

  // Instruction word: [7:5] opcode, [4] use-carry, [3:0] operand address
  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 5;
  localparam int unsigned UC_BIT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
`ifdef ALU_SEQ_STEP_EN
    , S_STEP_WAIT
`endif
  } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational instruction-byte decoder for alu_seq.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic [7:0]    instr_i,
  output logic [2:0]    op_o,
  output logic          use_carry_o,
  output logic [AW-1:0] addr_o,
  output logic          is_halt_o,
  output logic          writes_acc_o,
  output logic          writes_flags_o
);

  // Field extraction and per-opcode write-enable classification
  always_comb begin
    op_o           = instr_i[OP_MSB:OP_LSB];
    use_carry_o    = instr_i[UC_BIT];
    addr_o         = instr_i[AW-1:0];
    is_halt_o      = (instr_i == HALT_INSTR);
    writes_acc_o   = (instr_i[OP_MSB:OP_LSB] != OP_NOP);
    writes_flags_o = (instr_i[OP_MSB:OP_LSB] == OP_ADD) ||
                     (instr_i[OP_MSB:OP_LSB] == OP_SUB);
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle FETCH/DECODE/EXEC sequencer driving an external ALU
// from a 16-entry program memory and a 16-entry data memory.
// Optional single-step mode: define ALU_SEQ_STEP_EN (adds step port, STEP_WAIT).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_SEQ_STEP_EN
  input  logic             step,
`endif
  output logic [AW-1:0]    imem_addr,
  input  logic [7:0]       imem_rdata,
  output logic [AW-1:0]    dmem_addr,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_co,
  input  logic             alu_ov,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             halted,
  output logic             instr_done
);

  alu_seq_state_e   state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;

  logic [7:0]    dec_instr;
  logic [2:0]    dec_op;
  logic          dec_use_carry;
  logic [AW-1:0] dec_addr;
  logic          dec_is_halt;
  logic          dec_writes_acc;
  logic          dec_writes_flags;

  // One decoder serves both DECODE (fresh memory byte, for the early operand
  // address and halt detection) and EXEC (latched ir).
  assign dec_instr = (state_q == S_DECODE) ? imem_rdata : ir_q;

  alu_seq_decode #(.AW(AW)) u_decode (
    .instr_i        (dec_instr),
    .op_o           (dec_op),
    .use_carry_o    (dec_use_carry),
    .addr_o         (dec_addr),
    .is_halt_o      (dec_is_halt),
    .writes_acc_o   (dec_writes_acc),
    .writes_flags_o (dec_writes_flags)
  );

  // State and architectural registers; reset discards any in-flight EXEC write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          acc_d    = '0;
          flag_c_d = 1'b0;
          flag_v_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_rdata;
        state_d = dec_is_halt ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        if (dec_writes_acc) acc_d = alu_result;
        if (dec_writes_flags) begin
          flag_c_d = alu_co;
          flag_v_d = alu_ov;
        end
        pc_d = pc_q + AW'(1);
`ifdef ALU_SEQ_STEP_EN
        state_d = S_STEP_WAIT;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef ALU_SEQ_STEP_EN
      S_STEP_WAIT: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    imem_addr  = pc_q;
    dmem_addr  = dec_addr;
    alu_a      = acc_q;
    alu_b      = dmem_rdata;
    alu_op     = (state_q == S_EXEC) ? dec_op : OP_NOP;
    alu_ci     = (state_q == S_EXEC) & dec_writes_flags & dec_use_carry & flag_c_q;
    acc        = acc_q;
    flag_c     = flag_c_q;
    flag_v     = flag_v_q;
    halted     = (state_q == S_HALTED);
    instr_done = (state_q == S_EXEC);
    busy       = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC)
`ifdef ALU_SEQ_STEP_EN
                 || (state_q == S_STEP_WAIT)
`endif
                 ;
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with behavioural ALU, memories
// and an instruction-level reference model of the sequencer.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, start, step;
  logic [3:0] imem_addr, dmem_addr;
  logic [7:0] imem_rdata, dmem_rdata;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result, acc;
  logic       alu_ci, alu_co, alu_ov, flag_c, flag_v, busy, halted, instr_done;

  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ALU_SEQ_STEP_EN
    .step(step),
`endif
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_result(alu_result), .alu_co(alu_co), .alu_ov(alu_ov),
    .acc(acc), .flag_c(flag_c), .flag_v(flag_v),
    .busy(busy), .halted(halted), .instr_done(instr_done)
  );

  // Synchronous-read memories
  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
  end

  typedef struct packed { logic ov; logic co; logic [7:0] r; } alu_t;

  function automatic alu_t alu_f(input logic [2:0] op, input logic [7:0] a, b, input logic ci);
    alu_t   o;
    logic [8:0] t;
    o = '0;
    case (op)
      3'd0: o.r = a;
      3'd1: o.r = b;
      3'd2: begin
        t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        o.r = t[7:0]; o.co = t[8];
        o.ov = (a[7] == b[7]) && (o.r[7] != a[7]);
      end
      3'd3: begin
        t = {1'b0, a} - {1'b0, b} - {8'd0, ci};
        o.r = t[7:0]; o.co = t[8];
        o.ov = (a[7] != b[7]) && (o.r[7] != a[7]);
      end
      3'd4: o.r = ~a;
      3'd5: o.r = a & b;
      3'd6: o.r = a | b;
      default: o.r = a ^ b;
    endcase
    return o;
  endfunction

  always_comb {alu_ov, alu_co, alu_result} = alu_f(alu_op, alu_a, alu_b, alu_ci);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs per cycle offset after the start cycle
  typedef struct {
    logic busy, halted, done, ci, fc, fv;
    logic [2:0] op;
    logic [3:0] pc;
    logic [7:0] acc;
    int dm;
  } exp_t;
  exp_t ex [64];

  task automatic put(input int o, input logic b, h, d, input logic [2:0] op, input logic ci,
                     input logic [3:0] pc, input logic [7:0] a, input logic c, v, input int dm);
    if (o < 64) begin
      ex[o].busy = b; ex[o].halted = h; ex[o].done = d; ex[o].op = op; ex[o].ci = ci;
      ex[o].pc = pc; ex[o].acc = a; ex[o].fc = c; ex[o].fv = v; ex[o].dm = dm;
    end
  endtask

  // Instruction-level interpreter: each instruction is 3 cycles, HALT is 2
  task automatic build_model(input int len);
    logic [3:0] p;
    logic [7:0] a, ins;
    logic       c, v, ci, arith;
    alu_t       res;
    int         o;
    p = '0; a = '0; c = 1'b0; v = 1'b0; o = 1;
    while (o < len) begin
      ins = imem[p];
      put(o, 1, 0, 0, 3'd0, 0, p, a, c, v, -1); o++;
      put(o, 1, 0, 0, 3'd0, 0, p, a, c, v, int'(ins[3:0])); o++;
      if (ins == 8'h0F) begin
        while (o < len) begin put(o, 0, 1, 0, 3'd0, 0, p, a, c, v, -1); o++; end
      end else begin
        arith = (ins[7:5] == 3'd2) || (ins[7:5] == 3'd3);
        ci = arith && ins[4] && c;
        put(o, 1, 0, 1, ins[7:5], ci, p, a, c, v, int'(ins[3:0])); o++;
        res = alu_f(ins[7:5], a, dmem[ins[3:0]], ci);
        if (ins[7:5] != 3'd0) a = res.r;
        if (arith) begin c = res.co; v = res.ov; end
        p = p + 4'd1;
      end
    end
  endtask

  logic       mon_on = 1'b0;
  int         off = 0;
  int         mon_len = 0;
  int         first_halt;
  int         done_log[$];
  logic [7:0] obs_acc [64];
  logic       obs_fc  [64];
  logic [3:0] obs_pc  [64];

  // Compare process: checks every meaningful cycle against the model
  always @(negedge clk) begin
    if (mon_on) begin
      if (off >= 1) begin
        chk($sformatf("busy@%0d", off), busy, ex[off].busy);
        chk($sformatf("halted@%0d", off), halted, ex[off].halted);
        chk($sformatf("instr_done@%0d", off), instr_done, ex[off].done);
        chk($sformatf("alu_op@%0d", off), alu_op, ex[off].op);
        chk($sformatf("alu_ci@%0d", off), alu_ci, ex[off].ci);
        chk($sformatf("imem_addr@%0d", off), imem_addr, ex[off].pc);
        chk($sformatf("acc@%0d", off), acc, ex[off].acc);
        chk($sformatf("alu_a@%0d", off), alu_a, ex[off].acc);
        chk($sformatf("flag_c@%0d", off), flag_c, ex[off].fc);
        chk($sformatf("flag_v@%0d", off), flag_v, ex[off].fv);
        if (ex[off].dm >= 0) chk($sformatf("dmem_addr@%0d", off), dmem_addr, ex[off].dm);
        obs_acc[off] = acc; obs_fc[off] = flag_c; obs_pc[off] = imem_addr;
        if (instr_done) done_log.push_back(off);
        if (halted && first_halt < 0) first_halt = off;
      end
      off++;
      if (off >= mon_len) mon_on = 1'b0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin imem[i] = 8'h0F; dmem[i] = 8'h00; end
  endtask

  task automatic pulse_start(input logic mon);
    @(posedge clk); #1;
    start = 1'b1;
    if (mon) begin off = 0; mon_on = 1'b1; end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic arm(input int len);
    build_model(len);
    done_log.delete();
    first_halt = -1;
    mon_len = len;
  endtask

  task automatic wait_mon();
    for (int i = 0; i < 200 && mon_on; i++) @(posedge clk);
    if (mon_on) begin chk("monitor_timeout", 1, 0); mon_on = 1'b0; end
  endtask

  task automatic run_prog(input int len);
    arm(len);
    pulse_start(1'b1);
    wait_mon();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_ci", alu_ci, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_flag_v", flag_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr_done", instr_done, 0);
    rst = 1'b0;

`ifdef ALU_SEQ_STEP_EN
    clear_mem();
    imem[0] = 8'h21; imem[1] = 8'h0F; dmem[1] = 8'h7F;
    pulse_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("step_wait_busy", busy, 1);
    chk("step_wait_halted", halted, 0);
    chk("step_wait_done", instr_done, 0);
    chk("step_wait_acc", acc, 8'h7F);
    chk("step_wait_pc", imem_addr, 1);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    chk("step_fetch_busy", busy, 1);
    @(posedge clk); #1;
    chk("step_decode_halted", halted, 0);
    @(posedge clk); #1;
    chk("step_halted", halted, 1);
    chk("step_halted_busy", busy, 0);
    chk("step_halted_pc", imem_addr, 1);
`else
    // Load and add with signed overflow
    clear_mem();
    imem[0] = 8'h21; imem[1] = 8'h41; dmem[1] = 8'h7F;
    run_prog(12);
    chk("t1_acc", acc, 8'hFE);
    chk("t1_flag_v", flag_v, 1);
    chk("t1_flag_c", flag_c, 0);
    chk("t1_done_count", done_log.size(), 2);
    if (done_log.size() == 2) begin
      chk("t1_done0_cycle", done_log[0], 3);
      chk("t1_done1_cycle", done_log[1], 6);
    end
    chk("t1_halt_cycle", first_halt, 9);

    // Carry chain: LD FF, ADD 01, ADC 00
    clear_mem();
    imem[0] = 8'h22; imem[1] = 8'h41; imem[2] = 8'h53;
    dmem[1] = 8'h01; dmem[2] = 8'hFF; dmem[3] = 8'h00;
    run_prog(14);
    chk("t2_add_acc", obs_acc[7], 8'h00);
    chk("t2_add_c", obs_fc[7], 1);
    chk("t2_adc_acc", obs_acc[10], 8'h01);
    chk("t2_adc_c", obs_fc[10], 0);

    // Flag preservation across XOR
    imem[2] = 8'hE1;
    run_prog(14);
    chk("t3_acc", acc, 8'h01);
    chk("t3_flag_c", flag_c, 1);

    // Mixed ops incl. non-halt NOP encoding 0x05
    clear_mem();
    imem[0] = 8'h22; imem[1] = 8'h61; imem[2] = 8'h05; imem[3] = 8'h80;
    imem[4] = 8'hA2; imem[5] = 8'hC4;
    dmem[1] = 8'h01; dmem[2] = 8'hFF; dmem[4] = 8'h10;
    run_prog(24);
    chk("t4_acc", acc, 8'h11);
    chk("t4_flag_c", flag_c, 0);
    chk("t4_halt_cycle", first_halt, 21);

    // Reset during EXEC of an ADD
    clear_mem();
    imem[0] = 8'h21; imem[1] = 8'h41; dmem[1] = 8'h7F;
    pulse_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_pre_done", instr_done, 1);
    chk("t5_pre_op", alu_op, 3'd2);
    chk("t5_pre_acc", acc, 8'h7F);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_acc", acc, 0);
    chk("t5_flag_c", flag_c, 0);
    chk("t5_flag_v", flag_v, 0);
    chk("t5_busy", busy, 0);
    chk("t5_halted", halted, 0);
    chk("t5_done", instr_done, 0);
    chk("t5_pc", imem_addr, 0);
    rst = 1'b0;

    // PC wrap with start pulses while busy
    clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    arm(50);
    pulse_start(1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat (7) @(posedge clk);
      #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_mon();
    chk("t6_pc_last", obs_pc[48], 4'hF);
    chk("t6_pc_wrap", obs_pc[49], 4'h0);
    chk("t6_acc", obs_acc[49], 8'h00);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
